// File: rtl/core_pkg.sv
// Shared constants and types for the 64-tap FIR engine.
package core_pkg;
  localparam int NTAPS = 64;
  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int OW    = 32;

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [OW-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate: clear has priority over enable,
// the sum wraps modulo 2^OW.
module fir_mac
  import core_pkg::*;
(
  input  logic    clk1,
  input  logic    rstn,
  input  logic    clear,
  input  logic    en,
  input  sample_t a,
  input  sample_t b,
  output acc_t    acc
);

  acc_t prod_p0;
  acc_t acc_p1;

  // Two's-complement add that deliberately discards the carry out.
  function automatic acc_t wrap_add(input acc_t x, input acc_t y);
    return x + y;
  endfunction

  // Stage p0: full-precision product; 16x16 signed always fits in 32 bits.
  assign prod_p0 = acc_t'(a) * acc_t'(b);

  // Stage p1: accumulator register.
  always_ff @(posedge clk1) begin
    if (!rstn) begin
      acc_p1 <= '0;
    end else if (clear) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= wrap_add(acc_p1, prod_p0);
    end
  end

  assign acc = acc_p1;

endmodule

// File: rtl/core.sv
// 64-tap signed FIR engine: coefficient memory, circular sample history,
// and a control FSM sequencing one MAC per tap.
module core
  import core_pkg::*;
(
  input  logic          clk1,
  input  logic          rstn,
  input  logic          start,
  input  logic signed [DW-1:0] din,
  input  logic          valid_in,
  input  logic signed [DW-1:0] cin,
  input  logic [AW-1:0] caddr,
  input  logic          cload,
  output logic signed [OW-1:0] dout,
  output logic          valid_out
);

  sample_t       cmem [NTAPS];
  sample_t       imem [NTAPS];
  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] newest_ptr;
  logic [AW-1:0] tap_cnt;
  logic [AW-1:0] tap_idx;
  logic          accept;
  logic          mac_en;
  acc_t          acc;

  // A sample is taken only when idle, enabled, and not colliding with a coefficient write.
  assign accept  = (state == IDLE) && start && valid_in && !cload;
  assign mac_en  = (state == RUN);
  // Tap k pairs with the sample k steps older than the newest; 6-bit subtraction wraps the ring.
  assign tap_idx = newest_ptr - tap_cnt;

  fir_mac u_mac (
    .clk1  (clk1),
    .rstn  (rstn),
    .clear (accept),
    .en    (mac_en),
    .a     (cmem[tap_cnt]),
    .b     (imem[tap_idx]),
    .acc   (acc)
  );

  // Coefficient memory: writable in any state, cleared on reset.
  always_ff @(posedge clk1) begin
    if (!rstn) begin
      for (int i = 0; i < NTAPS; i++) cmem[i] <= '0;
    end else if (cload) begin
      cmem[caddr] <= cin;
    end
  end

  // Sample history ring: written only on an accepted sample, cleared on reset.
  always_ff @(posedge clk1) begin
    if (!rstn) begin
      for (int i = 0; i < NTAPS; i++) imem[i] <= '0;
    end else if (accept) begin
      imem[wr_ptr] <= din;
    end
  end

  // Control FSM with registered result and one-cycle valid pulse.
  always_ff @(posedge clk1) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      newest_ptr <= '0;
      tap_cnt    <= '0;
      dout       <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            newest_ptr <= wr_ptr;
            wr_ptr     <= wr_ptr + AW'(1);
            tap_cnt    <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          tap_cnt <= tap_cnt + AW'(1);
          if (tap_cnt == AW'(NTAPS - 1)) state <= DONE;
        end
        DONE: begin
          dout      <= acc;
          valid_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core.sv
// Directed bench for the FIR engine with a reference model and result scoreboard.
module tb_core;
  logic               clk1;
  logic               rstn;
  logic               start;
  logic signed [15:0] din;
  logic               valid_in;
  logic signed [15:0] cin;
  logic [5:0]         caddr;
  logic               cload;
  logic signed [31:0] dout;
  logic               valid_out;

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] m_coef [64];
  logic signed [15:0] m_hist [64];
  int                 m_wp;
  int                 m_newest;
  logic signed [31:0] sb [$];

  core dut (
    .clk1      (clk1),
    .rstn      (rstn),
    .start     (start),
    .din       (din),
    .valid_in  (valid_in),
    .cin       (cin),
    .caddr     (caddr),
    .cload     (cload),
    .dout      (dout),
    .valid_out (valid_out)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  function automatic logic signed [31:0] model_y();
    longint s;
    s = 0;
    for (int k = 0; k < 64; k++)
      s += longint'(m_coef[k]) * longint'(m_hist[(m_newest - k) & 63]);
    return s[31:0];
  endfunction

  task automatic check32(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_coef[i] = '0;
      m_hist[i] = '0;
    end
    m_wp = 0;
    m_newest = 0;
    sb.delete();
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) @(negedge clk1);
    rstn = 1'b1;
    model_clear();
  endtask

  task automatic load(input int a, input logic signed [15:0] v);
    cload = 1'b1;
    caddr = 6'(a);
    cin   = v;
    @(negedge clk1);
    cload = 1'b0;
    m_coef[a] = v;
  endtask

  // Drives one accepted sample; returns at the negedge after the accept edge.
  task automatic send(input logic signed [15:0] s);
    start    = 1'b1;
    din      = s;
    valid_in = 1'b1;
    @(negedge clk1);
    valid_in = 1'b0;
    m_hist[m_wp] = s;
    m_newest = m_wp;
    m_wp = (m_wp + 1) & 63;
    sb.push_back(model_y());
  endtask

  // Waits (bounded) for the pulse, compares with the scoreboard head, then checks pulse width.
  task automatic wait_result(input string tag, input int lat0, input bit chk_lat);
    int lat;
    logic signed [31:0] exp;
    lat = lat0;
    while (!valid_out && lat < 200) begin
      @(negedge clk1);
      lat++;
    end
    checks++;
    assert (valid_out === 1'b1) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=1", tag, valid_out);
    end
    if (valid_out === 1'b1) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 32'sd0;
      check32(tag, dout, exp);
      if (chk_lat) check32({tag, "_latency"}, lat, 66);
      @(negedge clk1);
      check32({tag, "_pulse_width"}, 32'(valid_out), 0);
    end
  endtask

  task automatic expect_no_pulse(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk1);
      if (valid_out) seen++;
    end
    check32(tag, seen, 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; din = '0; valid_in = 1'b0;
    cin = '0; caddr = '0; cload = 1'b0;
    model_clear();
    @(negedge clk1);

    // Reset state and all-zero coefficients
    do_reset(2);
    check32("reset_dout", dout, 0);
    check32("reset_valid", 32'(valid_out), 0);
    send(16'sd7);
    wait_result("zero_coef", 1, 1'b1);

    // Impulse on tap 0
    load(0, 16'sd1);
    send(16'sd5);
    wait_result("impulse", 1, 1'b1);
    check32("impulse_const", dout, 5);

    // Running sum with all taps = 1
    do_reset(2);
    for (int k = 0; k < 64; k++) load(k, 16'sd1);
    send(16'sd1); wait_result("rsum1", 1, 1'b0);
    send(16'sd2); wait_result("rsum2", 1, 1'b0);
    send(16'sd3); wait_result("rsum3", 1, 1'b0);
    check32("rsum3_const", dout, 6);

    // Sign and width
    do_reset(2);
    load(0, -16'sd2);
    send(-16'sd32768); wait_result("neg_times_neg", 1, 1'b0);
    check32("neg_const", dout, 65536);
    do_reset(2);
    load(0, -16'sd32768);
    load(1, -16'sd32768);
    send(-16'sd32768); wait_result("wrap_first", 1, 1'b0);
    send(-16'sd32768); wait_result("wrap_second", 1, 1'b0);
    check32("wrap_const", dout, -32'sd2147483648);

    // Delay line wrap via tap 63
    do_reset(2);
    load(63, 16'sd1);
    for (int n = 1; n <= 65; n++) begin
      send(16'(n));
      wait_result($sformatf("tap63_n%0d", n), 1, 1'b0);
    end
    check32("tap63_last_const", dout, 2);

    // Dropped samples
    do_reset(2);
    load(0, 16'sd1);
    load(1, 16'sd1);
    send(16'sd10);
    din = 16'sd999; valid_in = 1'b1;
    repeat (5) @(negedge clk1);
    valid_in = 1'b0;
    wait_result("drop_run_base", 6, 1'b0);
    start = 1'b0; din = 16'sd777; valid_in = 1'b1;
    @(negedge clk1);
    valid_in = 1'b0;
    expect_no_pulse("drop_nostart", 80);
    start = 1'b1; din = 16'sd555; valid_in = 1'b1;
    cload = 1'b1; caddr = 6'd5; cin = m_coef[5];
    @(negedge clk1);
    valid_in = 1'b0; cload = 1'b0;
    expect_no_pulse("drop_cload", 80);
    send(16'sd20);
    wait_result("drop_after", 1, 1'b0);
    check32("drop_after_const", dout, 30);

    // Reset mid-computation at E30
    send(16'sd3);
    repeat (29) @(negedge clk1);
    rstn = 1'b0;
    @(negedge clk1);
    rstn = 1'b1;
    model_clear();
    check32("abort_dout", dout, 0);
    check32("abort_valid", 32'(valid_out), 0);
    expect_no_pulse("abort_no_pulse", 80);
    check32("abort_dout_hold", dout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
